// File: rtl/sh2_bus_pkg.sv
// sh2_bus_pkg: shared state, size codes and area decode for the SH-2 bus master
package sh2_bus_pkg;
  typedef enum logic [1:0] {IDLE, T1, TW, T2} state_e;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_LONG = 2'b10;
  function automatic logic [3:0] cs_onehot(input logic [1:0] area);
    return 4'b0001 << area;
  endfunction
endpackage

// File: rtl/sh2_bus_master.sv
// sh2_bus_master: SH-2 16-bit bus cycle generator; define SH2_BUS_WAITIN_EN to let WAIT_N stretch cycles
module sh2_bus_master
  import sh2_bus_pkg::*;
#(
  parameter logic [1:0] W0 = 2'd0,
  parameter logic [1:0] W1 = 2'd0,
  parameter logic [1:0] W2 = 2'd1,
  parameter logic [1:0] W3 = 2'd2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        REQ,
  input  logic [26:0] ADDR,
  input  logic        WR,
  input  logic [1:0]  SZ,
  input  logic [31:0] DI,
  output logic [31:0] DO,
  output logic        ACK,
  output logic        BUSY,
  output logic [24:1] A,
  output logic [15:0] D_O,
  input  logic [15:0] D_I,
  output logic        BS_N,
  output logic        CS0_N,
  output logic        CS1_N,
  output logic        CS2_N,
  output logic        CS3_N,
  output logic        RD_WR_N,
  output logic        RD_N,
  output logic [1:0]  WE_N,
  input  logic        WAIT_N
);
  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d, sz_q, sz_d, wn, area;
  logic        half_q, half_d, wr_q, wr_d, ack_q, ack_d, stretch;
  logic [26:0] addr_q, addr_d;
  logic [31:0] di_q, di_d, do_q, do_d;
  logic [24:1] a_q, a_d;
  logic [15:0] d_o_q, d_o_d;
  logic [3:0]  cs_n_q, cs_n_d;
  logic        bs_n_q, bs_n_d, rd_n_q, rd_n_d, rd_wr_n_q, rd_wr_n_d;
  logic [1:0]  we_n_q, we_n_d, lane;
  logic        active, is_long;

`ifdef SH2_BUS_WAITIN_EN
  assign stretch = ~WAIT_N;
`else
  logic unused_wait_n;
  assign unused_wait_n = WAIT_N;
  assign stretch = 1'b0;
`endif

  assign area = (state_q == IDLE) ? ADDR[26:25] : addr_q[26:25];
  assign wn = area[1] ? (area[0] ? W3 : W2) : (area[0] ? W1 : W0);

  // Next-state, request latch, wait counter, read capture and completion pulse
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    half_d = half_q;
    addr_d = addr_q;
    wr_d = wr_q;
    sz_d = sz_q;
    di_d = di_q;
    do_d = do_q;
    ack_d = 1'b0;
    if (CE_R) begin
      case (state_q)
        IDLE: if (REQ && !ack_q) begin
          state_d = T1;
          addr_d = ADDR;
          wr_d = WR;
          sz_d = SZ;
          di_d = DI;
          cnt_d = wn;
          half_d = 1'b0;
        end
        T1: state_d = (cnt_q != 2'd0 || stretch) ? TW : T2;
        TW: begin
          cnt_d = (cnt_q > 2'd1) ? cnt_q - 2'd1 : 2'd0;
          state_d = (cnt_q > 2'd1 || stretch) ? TW : T2;
        end
        T2: begin
          if (!wr_q)
            do_d = sz_q == SZ_BYTE ? {24'h0, addr_q[0] ? D_I[7:0] : D_I[15:8]} :
                   sz_q == SZ_WORD ? {16'h0, D_I} :
                   half_q ? {do_q[31:16], D_I} : {D_I, 16'h0};
          if (sz_q >= SZ_LONG && !half_q) begin
            state_d = T1;
            half_d = 1'b1;
            cnt_d = wn;
          end else begin
            state_d = IDLE;
            ack_d = 1'b1;
          end
        end
      endcase
    end
  end

  // Bus pin values for the state being entered, so the pins come straight from flops
  always_comb begin
    active = state_d != IDLE;
    is_long = sz_d >= SZ_LONG;
    lane = sz_d == SZ_BYTE ? (addr_d[0] ? 2'b10 : 2'b01) : 2'b00;
    a_d = active ? (is_long ? {addr_d[24:2], half_d} : addr_d[24:1]) : a_q;
    d_o_d = (active && wr_d) ? (sz_d == SZ_BYTE ? {2{di_d[7:0]}} :
                                (is_long && !half_d) ? di_d[31:16] : di_d[15:0]) : d_o_q;
    cs_n_d = active ? ~cs_onehot(addr_d[26:25]) : 4'hf;
    bs_n_d = state_d != T1;
    rd_wr_n_d = !active || !wr_d;
    rd_n_d = !active || wr_d;
    we_n_d = (wr_d && (state_d == TW || state_d == T2)) ? lane : 2'b11;
  end

  // State and bus registers advance on CE_R; ACK and DO update every clock so ACK is one CLK wide
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q <= 2'd0;
      half_q <= 1'b0;
      addr_q <= '0;
      wr_q <= 1'b0;
      sz_q <= 2'd0;
      di_q <= '0;
      do_q <= '0;
      ack_q <= 1'b0;
      a_q <= '0;
      d_o_q <= '0;
      cs_n_q <= 4'hf;
      bs_n_q <= 1'b1;
      rd_n_q <= 1'b1;
      rd_wr_n_q <= 1'b1;
      we_n_q <= 2'b11;
    end else begin
      ack_q <= ack_d;
      do_q <= do_d;
      if (CE_R) begin
        state_q <= state_d;
        cnt_q <= cnt_d;
        half_q <= half_d;
        addr_q <= addr_d;
        wr_q <= wr_d;
        sz_q <= sz_d;
        di_q <= di_d;
        a_q <= a_d;
        d_o_q <= d_o_d;
        cs_n_q <= cs_n_d;
        bs_n_q <= bs_n_d;
        rd_n_q <= rd_n_d;
        rd_wr_n_q <= rd_wr_n_d;
        we_n_q <= we_n_d;
      end
    end
  end

  assign DO = do_q;
  assign ACK = ack_q;
  assign BUSY = state_q != IDLE;
  assign A = a_q;
  assign D_O = d_o_q;
  assign BS_N = bs_n_q;
  assign {CS3_N, CS2_N, CS1_N, CS0_N} = cs_n_q;
  assign RD_WR_N = rd_wr_n_q;
  assign RD_N = rd_n_q;
  assign WE_N = we_n_q;
endmodule

// File: tb/tb_sh2_bus_master.sv
// tb_sh2_bus_master: directed vector bench for sh2_bus_master
`timescale 1ns/1ps
module tb_sh2_bus_master;
  logic CLK = 0, RST_N = 0, CE_R = 0, REQ = 0, WR = 0, WAIT_N = 1;
  logic [26:0] ADDR = '0;
  logic [1:0] SZ = '0;
  logic [31:0] DI = '0;
  logic [15:0] D_I = '0;
  logic [31:0] DO;
  logic ACK, BUSY, BS_N, CS0_N, CS1_N, CS2_N, CS3_N, RD_WR_N, RD_N;
  logic [24:1] A;
  logic [15:0] D_O;
  logic [1:0] WE_N;

  sh2_bus_master dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .REQ(REQ), .ADDR(ADDR), .WR(WR), .SZ(SZ),
    .DI(DI), .DO(DO), .ACK(ACK), .BUSY(BUSY), .A(A), .D_O(D_O), .D_I(D_I), .BS_N(BS_N),
    .CS0_N(CS0_N), .CS1_N(CS1_N), .CS2_N(CS2_N), .CS3_N(CS3_N), .RD_WR_N(RD_WR_N),
    .RD_N(RD_N), .WE_N(WE_N), .WAIT_N(WAIT_N)
  );

  always #5 CLK = ~CLK;

  int ce_div = 0, ce_cnt = 0;
  logic ce_last = 0;
  always @(negedge CLK) begin
    if (ce_div == 0) CE_R = 0;
    else begin
      ce_cnt = (ce_cnt + 1 >= ce_div) ? 0 : ce_cnt + 1;
      CE_R = (ce_cnt == 0);
    end
  end
  always @(posedge CLK) ce_last <= CE_R;

  typedef struct {
    logic wr; logic [1:0] sz; logic [26:0] addr; logic [31:0] di; logic [15:0] dh, dl;
    logic [31:0] xdo; int xcs, xbs, xrd, xwec; logic [1:0] xwe;
    logic [23:0] xa0, xa1; logic [15:0] xd0, xd1; bit hold, wl;
  } vec_t;

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  int r_cs, r_bsclk, r_nb, r_rd, r_wec, r_ws, r_bad, r_ackw;
  logic [1:0] r_wev;
  logic [23:0] r_a0, r_a1;
  logic [15:0] r_d0, r_d1;
  logic [31:0] r_do;
  logic r_rw;
  bit r_done;

  function automatic logic [81:0] snap();
    return {BUSY, A, D_O, BS_N, CS0_N, CS1_N, CS2_N, CS3_N, RD_N, WE_N, RD_WR_N, DO};
  endfunction

  task automatic run_txn(input vec_t v);
    logic pbs;
    bit got;
    logic [81:0] prev;
    @(negedge CLK);
    ADDR = v.addr; WR = v.wr; SZ = v.sz; DI = v.di; D_I = v.dh;
    WAIT_N = v.wl ? 1'b0 : 1'b1;
    REQ = 1;
    r_cs = 0; r_bsclk = 0; r_nb = 0; r_rd = 0; r_wec = 0; r_ws = 0; r_bad = 0; r_ackw = 0;
    r_wev = 2'b11; r_a0 = '1; r_a1 = '1; r_d0 = '1; r_d1 = '1; r_do = '1; r_rw = 1'bx;
    r_done = 0; got = 0; pbs = 1; prev = snap();
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      if (!ce_last && snap() != prev) r_bad++;
      prev = snap();
      if (!(CS0_N & CS1_N & CS2_N & CS3_N)) r_cs++;
      if (!BS_N) r_bsclk++;
      if (!BS_N && pbs) begin
        if (r_nb == 0) begin r_a0 = A; r_d0 = D_O; r_rw = RD_WR_N; end
        else begin r_a1 = A; r_d1 = D_O; end
        r_nb++;
      end
      pbs = BS_N;
      D_I = (r_nb >= 2) ? v.dl : v.dh;
      if (!RD_N) r_rd++;
      if (WE_N != 2'b11) begin r_wec++; r_wev = WE_N; if (!BS_N) r_ws++; end
      if (v.wl && r_cs == 6) WAIT_N = 1;
      if (ACK) begin
        if (!got) r_do = DO;
        got = 1; r_ackw++;
        if (!v.hold) REQ = 0;
      end else if (got) begin
        REQ = 0; r_done = 1;
        break;
      end
    end
    REQ = 0; WAIT_N = 1;
  endtask

  task automatic check_txn(input string nm, input vec_t v, input int div);
    chk({nm, "_done"}, 32'(r_done), 1);
    chk({nm, "_cs_clks"}, r_cs, v.xcs * div);
    chk({nm, "_bs_starts"}, r_nb, v.xbs);
    chk({nm, "_bs_clks"}, r_bsclk, v.xbs * div);
    chk({nm, "_rd_clks"}, r_rd, v.xrd * div);
    chk({nm, "_we_clks"}, r_wec, v.xwec * div);
    chk({nm, "_we_val"}, 32'(r_wev), 32'(v.xwe));
    chk({nm, "_we_in_t1"}, r_ws, 0);
    chk({nm, "_rd_wr_n"}, 32'(r_rw), 32'(!v.wr));
    chk({nm, "_a0"}, 32'(r_a0), 32'(v.xa0));
    if (v.xbs == 2) chk({nm, "_a1"}, 32'(r_a1), 32'(v.xa1));
    if (v.wr) chk({nm, "_d_o0"}, 32'(r_d0), 32'(v.xd0));
    if (v.wr && v.xbs == 2) chk({nm, "_d_o1"}, 32'(r_d1), 32'(v.xd1));
    if (!v.wr) chk({nm, "_do"}, r_do, v.xdo);
    chk({nm, "_ack_width"}, r_ackw, 1);
    chk({nm, "_off_ce_change"}, r_bad, 0);
    repeat (3) @(negedge CLK);
    chk({nm, "_idle_after"}, 32'({BUSY, ACK, BS_N, CS0_N & CS1_N & CS2_N & CS3_N}), 32'(4'b0011));
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_strobes"}, 32'({BS_N, CS3_N, CS2_N, CS1_N, CS0_N, RD_N, WE_N, RD_WR_N}), 32'(9'h1ff));
    chk({nm, "_busy_ack"}, 32'({BUSY, ACK}), 0);
    chk({nm, "_a"}, 32'(A), 0);
    chk({nm, "_d_o"}, 32'(D_O), 0);
    chk({nm, "_do"}, DO, 0);
  endtask

  vec_t tv[8];
  vec_t wv, rv;
  int found;

  initial begin
    tv[0] = '{1'b0, 2'b01, 27'h0000100, 32'h0, 16'hA55A, 16'h0, 32'h0000A55A, 2, 1, 2, 0, 2'b11, 24'h000080, 24'h0, 16'h0, 16'h0, 1'b1, 1'b0};
    tv[1] = '{1'b1, 2'b10, 27'h2000004, 32'h12345678, 16'h0, 16'h0, 32'h0, 4, 2, 0, 2, 2'b00, 24'h000002, 24'h000003, 16'h1234, 16'h5678, 1'b0, 1'b0};
    tv[2] = '{1'b1, 2'b00, 27'h4000003, 32'h000000C3, 16'h0, 16'h0, 32'h0, 3, 1, 0, 2, 2'b10, 24'h000001, 24'h0, 16'hC3C3, 16'h0, 1'b0, 1'b0};
    tv[3] = '{1'b0, 2'b00, 27'h4000010, 32'h0, 16'hBEEF, 16'h0, 32'h000000BE, 3, 1, 3, 0, 2'b11, 24'h000008, 24'h0, 16'h0, 16'h0, 1'b0, 1'b0};
    tv[4] = '{1'b0, 2'b00, 27'h4000011, 32'h0, 16'hBEEF, 16'h0, 32'h000000EF, 3, 1, 3, 0, 2'b11, 24'h000008, 24'h0, 16'h0, 16'h0, 1'b0, 1'b0};
    tv[5] = '{1'b0, 2'b10, 27'h6000002, 32'h0, 16'hCAFE, 16'hF00D, 32'hCAFEF00D, 8, 2, 8, 0, 2'b11, 24'h000000, 24'h000001, 16'h0, 16'h0, 1'b0, 1'b0};
    tv[6] = '{1'b1, 2'b01, 27'h2000101, 32'h1234BEEF, 16'h0, 16'h0, 32'h0, 2, 1, 0, 1, 2'b00, 24'h000080, 24'h0, 16'hBEEF, 16'h0, 1'b0, 1'b0};
    tv[7] = '{1'b1, 2'b11, 27'h0000007, 32'hDEADBEEF, 16'h0, 16'h0, 32'h0, 4, 2, 0, 2, 2'b00, 24'h000002, 24'h000003, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0};
    wv = '{1'b0, 2'b01, 27'h6000000, 32'h0, 16'h1357, 16'h0, 32'h00001357, 4, 1, 4, 0, 2'b11, 24'h0, 24'h0, 16'h0, 16'h0, 1'b0, 1'b1};
`ifdef SH2_BUS_WAITIN_EN
    wv.xcs = 7; wv.xrd = 7;
`endif

    repeat (3) @(negedge CLK);
    chk_reset_state("reset_no_ce");
    RST_N = 1; ce_div = 1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 8; i++) begin
      run_txn(tv[i]);
      check_txn($sformatf("vec%0d", i), tv[i], 1);
    end

    run_txn(wv);
    check_txn("wait_n", wv, 1);

    ce_div = 3;
    rv = tv[0]; rv.hold = 0;
    run_txn(rv);
    check_txn("ce3_word_rd", rv, 3);
    run_txn(tv[1]);
    check_txn("ce3_long_wr", tv[1], 3);
    ce_div = 1;
    repeat (2) @(negedge CLK);

    @(negedge CLK);
    ADDR = tv[2].addr; WR = 1; SZ = tv[2].sz; DI = tv[2].di; REQ = 1;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge CLK);
      if (WE_N != 2'b11 && BS_N) found = 1;
    end
    chk("abort_reached_tw", found, 1);
    RST_N = 0;
    @(negedge CLK);
    chk_reset_state("abort_reset");
    REQ = 0;
    @(negedge CLK);
    RST_N = 1;
    repeat (2) @(negedge CLK);
    chk("abort_no_ack", 32'({BUSY, ACK}), 0);
    run_txn(tv[2]);
    check_txn("after_abort", tv[2], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
